// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 receive-side monitor that rebuilds the panel frame and flags protocol faults.
// Define HUB75_CAPTURE_ORDER_CHECK_EN to track the expected row-pair address and raise order_err.
module hub75_capture #(
    parameter int COLS = 32,
    parameter int ROWS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [5:0]                  rgb,
    input  logic                        lat,
    input  logic                        oe,
    input  logic [$clog2(ROWS/2)-1:0]   abc,
    input  logic [$clog2(ROWS)-1:0]     rd_row,
    input  logic [$clog2(COLS)-1:0]     rd_col,
    output logic [2:0]                  rd_pixel,
    output logic                        frame_done,
    output logic [7:0]                  frame_count,
    output logic                        order_err,
    output logic                        short_err
);
    localparam int HALF = ROWS / 2;
    localparam int AW = $clog2(HALF);
    localparam int NW = $clog2(COLS + 1);

    typedef enum logic [1:0] {SHIFT, COMMIT_TOP, COMMIT_BOT} state_t;

    state_t                    state_q, state_d;
    logic [COLS-1:0][2:0]      top_sr_q, top_sr_d, bot_sr_q, bot_sr_d;
    logic [COLS-1:0][2:0]      top_hold_q, top_hold_d, bot_hold_q, bot_hold_d;
    logic [NW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             row_q, row_d;
    logic                      short_q, short_d;
    logic [7:0]                fc_q, fc_d;
    logic [2:0]                pix_q, pix_d;
    logic [ROWS-1:0][COLS-1:0][2:0] fb_q;
    logic                      unused_oe;

    // oe is only a display strobe; it never touches the captured image
    assign unused_oe = oe;

    always_comb begin
        state_d    = state_q;
        top_sr_d   = top_sr_q;
        bot_sr_d   = bot_sr_q;
        top_hold_d = top_hold_q;
        bot_hold_d = bot_hold_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        short_d    = short_q;
        fc_d       = fc_q;
        frame_done = 1'b0;
        if (state_q != SHIFT || !lat) begin
            top_sr_d = {rgb[5:3], top_sr_q[COLS-1:1]};
            bot_sr_d = {rgb[2:0], bot_sr_q[COLS-1:1]};
            cnt_d    = (cnt_q == NW'(COLS)) ? cnt_q : cnt_q + 1'b1;
        end
        if (state_q == SHIFT && lat) begin
            top_hold_d = top_sr_q;
            bot_hold_d = bot_sr_q;
            row_d      = abc;
            short_d    = short_q | (cnt_q < NW'(COLS));
            cnt_d      = '0;
            state_d    = COMMIT_TOP;
        end else if (state_q != SHIFT) begin
            short_d    = short_q | lat;
            state_d    = (state_q == COMMIT_TOP) ? COMMIT_BOT : SHIFT;
            frame_done = (state_q == COMMIT_BOT) && (row_q == AW'(HALF - 1));
            fc_d       = fc_q + {7'd0, frame_done};
        end
        pix_d = (32'(rd_row) < ROWS && 32'(rd_col) < COLS) ? fb_q[rd_row][rd_col] : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SHIFT;
            top_sr_q   <= '0;
            bot_sr_q   <= '0;
            top_hold_q <= '0;
            bot_hold_q <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            short_q    <= 1'b0;
            fc_q       <= '0;
            pix_q      <= '0;
            fb_q       <= '0;
        end else begin
            state_q    <= state_d;
            top_sr_q   <= top_sr_d;
            bot_sr_q   <= bot_sr_d;
            top_hold_q <= top_hold_d;
            bot_hold_q <= bot_hold_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            short_q    <= short_d;
            fc_q       <= fc_d;
            pix_q      <= pix_d;
            if (state_q == COMMIT_TOP) fb_q[{1'b0, row_q}] <= top_hold_q;
            if (state_q == COMMIT_BOT) fb_q[{1'b1, row_q}] <= bot_hold_q;
        end
    end

`ifdef HUB75_CAPTURE_ORDER_CHECK_EN
    logic [AW-1:0] exp_q;
    logic          order_q;

    // expected row resyncs to the observed one so a single skip flags once
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q   <= '0;
            order_q <= 1'b0;
        end else if (state_q == COMMIT_TOP) begin
            order_q <= order_q | (row_q != exp_q);
            exp_q   <= row_q + 1'b1;
        end
    end

    assign order_err = order_q;
`else
    assign order_err = 1'b0;
`endif

    assign rd_pixel    = pix_q;
    assign frame_count = fc_q;
    assign short_err   = short_q;
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: vector table plus readback scoreboard for the HUB75 capture block.
module tb_hub75_capture;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lat = 1'b0;
    logic       oe = 1'b0;
    logic [5:0] rgb = '0;
    logic [2:0] abc = '0;
    logic [3:0] rd_row = '0;
    logic [4:0] rd_col = '0;
    logic [2:0] rd_pixel;
    logic       frame_done, order_err, short_err;
    logic [7:0] frame_count;

    int n_tests = 0, n_fail = 0, cyc_n = 0, fd_cnt = 0, fd_at = -1, l7 = 0;

    typedef struct {int r; int c; logic [2:0] e;} vec_t;
    vec_t sb[$];
    vec_t tbl[12];

`ifdef HUB75_CAPTURE_ORDER_CHECK_EN
    localparam logic ORD_EXP = 1'b1;
`else
    localparam logic ORD_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    hub75_capture dut (
        .clk(clk), .reset(reset), .rgb(rgb), .lat(lat), .oe(oe), .abc(abc),
        .rd_row(rd_row), .rd_col(rd_col), .rd_pixel(rd_pixel), .frame_done(frame_done),
        .frame_count(frame_count), .order_err(order_err), .short_err(short_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        oe = ~oe;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_at = cyc_n;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int r, input int c, input logic [2:0] e);
        vec_t v;
        rd_row = 4'(r);
        rd_col = 5'(c);
        sb.push_back('{r, c, e});
        cyc();
        v = sb.pop_front();
        chk($sformatf("rd[%0d][%0d]", v.r, v.c), 32'(rd_pixel), 32'(v.e));
    endtask

    task automatic shift(input logic [5:0] d);
        rgb = d;
        lat = 1'b0;
        cyc();
    endtask

    task automatic latch(input int a);
        lat = 1'b1;
        abc = 3'(a);
        cyc();
        lat = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lat = 1'b0;
        rgb = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pix"}, 32'(rd_pixel), 0);
        chk({nm, "_fd"}, 32'(frame_done), 0);
        chk({nm, "_fc"}, 32'(frame_count), 0);
        chk({nm, "_ord"}, 32'(order_err), 0);
        chk({nm, "_short"}, 32'(short_err), 0);
    endtask

    function automatic logic [2:0] pix(input int r, input int c);
        return ((r + c) % 2 == 1) ? 3'(r ^ (r >> 1)) : 3'(~c);
    endfunction

    initial begin
        tbl = '{'{3, 0, 3'b100}, '{3, 1, 3'b000}, '{3, 2, 3'b100}, '{3, 30, 3'b100},
                '{3, 31, 3'b000}, '{11, 0, 3'b010}, '{11, 17, 3'b010}, '{11, 31, 3'b010},
                '{2, 0, 3'b000}, '{4, 6, 3'b000}, '{10, 31, 3'b000}, '{12, 0, 3'b000}};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 32; i++) shift({(i % 2 == 0) ? 3'b100 : 3'b000, 3'b010});
        latch(3);
        chk("load_fd_top", 32'(frame_done), 0);
        cyc();
        chk("load_fd_bot", 32'(frame_done), 0);
        chk("load_short", 32'(short_err), 0);
        cyc();
        for (int i = 0; i < 12; i++) rd(tbl[i].r, tbl[i].c, tbl[i].e);

        do_reset();
        fd_cnt = 0;
        for (int a = 0; a < 8; a++) begin
            for (int i = 0; i < 32; i++) shift({pix(a, i), pix(a + 8, i)});
            latch(a);
            if (a == 7) l7 = cyc_n;
        end
        cyc();
        cyc();
        chk("frame_fd_count", 32'(fd_cnt), 1);
        chk("frame_fd_cycle", 32'(fd_at), 32'(l7 + 1));
        chk("frame_count", 32'(frame_count), 1);
        chk("frame_short", 32'(short_err), 0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) rd(r, c, pix(r, c));

        do_reset();
        for (int i = 0; i < 32; i++) shift({3'(i), 3'(~i)});
        latch(1);
        chk("short_exact_cols", 32'(short_err), 0);
        for (int j = 0; j < 20; j++) shift({3'(j + 5), 3'(j ^ 3)});
        latch(2);
        chk("short_err", 32'(short_err), 1);
        cyc();
        cyc();
        for (int c = 0; c < 32; c++) begin
            rd(2, c, (c < 12) ? 3'(c + 20) : 3'(c - 12 + 5));
            rd(10, c, (c < 12) ? 3'(~(c + 20)) : 3'((c - 12) ^ 3));
            rd(1, c, 3'(c));
        end

        do_reset();
        for (int i = 0; i < 32; i++) shift({3'(i * 3), 3'(i + 1)});
        latch(4);
        latch(5);
        chk("overrun_short", 32'(short_err), 1);
        cyc();
        chk("overrun_fd", 32'(fd_cnt), 1);
        for (int c = 0; c < 32; c++) begin
            rd(4, c, 3'(c * 3));
            rd(12, c, 3'(c + 1));
        end
        rd(5, 0, 3'b000);
        rd(13, 31, 3'b000);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) shift({3'(i + k), 3'(i)});
            latch((k == 2) ? 3 : k);
        end
        chk("order_before", 32'(order_err), 0);
        cyc();
        chk("order_after", 32'(order_err), 32'(ORD_EXP));
        chk("order_short", 32'(short_err), 0);

        do_reset();
        for (int i = 0; i < 32; i++) shift(6'b111111 ^ 6'(i));
        latch(6);
        reset = 1'b1;
        cyc();
        chk_all_zero("midreset");
        reset = 1'b0;
        cyc();
        cyc();
        for (int c = 0; c < 32; c++) begin
            rd(6, c, 3'b000);
            rd(14, c, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
